uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` byte sources (scan-code decoder, status reporter, echo path, debug). It accepts one byte per handshake from a requester and hands it to the transmitter. It then waits for frame completion, enforces an inter-frame gap, and recovers from a hung transmitter with a watchdog. It sits between the requesting blocks and the UART TX core that drives `TXD_o`.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ
// byte sources. Grants one byte per handshake, waits for the frame to
// finish (or a watchdog to expire), then holds an inter-frame gap.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_done_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_e;

  state_e              state_q;
  logic [PW-1:0]       ptr_q;
  logic [15:0]         cnt_q;   // watchdog in WAIT, gap timer in GAP
  logic [N_REQ-1:0]    ack_q;
  logic                tx_start_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [N_REQ-1:0]    grant_q;
  logic                err_q;

  // First pending request at or after ptr, wrapping. Scanned backwards so
  // the closest one to ptr is the last (winning) assignment.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [PW-1:0]    ptr);
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) r = {1'b1, idx[PW-1:0]};
    end
    return r;
  endfunction

  logic [PW:0]      pick;
  logic             pick_vld;
  logic [PW-1:0]    win;
  logic [N_REQ-1:0] win_oh;
  logic [PW-1:0]    ptr_d;
  logic [31:0]      cnt_inc;
  logic             wd_hit;
  logic             gap_last;

  // Arbitration result and timer compares
  always_comb begin
    pick     = rr_pick(req_i, ptr_q);
    pick_vld = pick[PW];
    win      = pick[PW-1:0];
    win_oh   = N_REQ'(1) << win;
    ptr_d    = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    cnt_inc  = 32'(cnt_q) + 32'd1;
    wd_hit   = (TIMEOUT_CYC != 0) && (cnt_inc == 32'(TIMEOUT_CYC));
    gap_last = (cnt_inc >= 32'(GAP_CYC));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld && !tx_busy_i) begin
            state_q    <= START;
            tx_start_q <= 1'b1;
            ack_q      <= win_oh;
            grant_q    <= win_oh;
            tx_data_q  <= data_i[int'(win)*DATA_W +: DATA_W];
            ptr_q      <= ptr_d;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // done takes precedence over a watchdog expiry in the same cycle
          if (tx_done_i || wd_hit) begin
            err_q   <= !tx_done_i;
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (gap_last) state_q <= IDLE;
          else          cnt_q   <= cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign grant_o    = grant_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level round-robin model (integer
// pointer + first-set scan) and a scripted transmitter with frame length
// chosen per frame; random request sets, holds, withdrawals and busy.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 2;
  localparam int T = 100;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   data_i;
  logic [N-1:0]     ack_o;
  logic             tx_start_o;
  logic [W-1:0]     tx_data_o;
  logic             tx_busy_i;
  logic             tx_done_i;
  logic [N-1:0]     grant_o;
  logic             err_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .grant_o(grant_o),
    .err_o(err_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int mptr  = 0;   // model round-robin pointer

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[(mptr + i) % N]) return (mptr + i) % N;
    return -1;
  endfunction

  // One frame from IDLE: optional busy hold-off, grant, transmit for len
  // WAIT cycles (len > T means the transmitter hangs), then gap.
  task automatic frame(input logic [N-1:0] r, input int busy_cyc, input int len,
                       input bit hold, output int w);
    logic [N-1:0] oh;
    req_i     = r;
    tx_busy_i = (busy_cyc > 0);
    for (int b = 0; b < busy_cyc; b++) begin
      tick();
      chk("busy_hold", {27'd0, tx_start_o, ack_o}, 32'd0);
      if (b == busy_cyc - 1) tx_busy_i = 1'b0;
    end
    w  = pick(r);
    oh = N'(1) << w;
    tick();
    chk("start", tx_start_o, 1);
    chk("ack",   ack_o, oh);
    chk("grant", grant_o, oh);
    chk("data",  tx_data_o, data_i[w*W +: W]);
    mptr = (w + 1) % N;
    if (!hold) req_i[w] = 1'b0;
    tx_busy_i = 1'b1;
    if (len > T) begin
      for (int c = 1; c <= T; c++) begin
        tick();
        chk("wait_quiet", {26'd0, tx_start_o, ack_o, err_o}, 32'd0);
        chk("wait_grant", grant_o, oh);
      end
      tick();
      chk("err_pulse", err_o, 1);
      chk("err_grant_clr", grant_o, 0);
      tx_busy_i = 1'b0;
    end else begin
      for (int c = 1; c <= len; c++) begin
        tick();
        chk("wait_quiet", {26'd0, tx_start_o, ack_o, err_o}, 32'd0);
        chk("wait_grant", grant_o, oh);
        if (c == len) tx_done_i = 1'b1;
      end
      tick();
      tx_done_i = 1'b0;
      tx_busy_i = 1'b0;
      chk("done_no_err", err_o, 0);
      chk("done_grant_clr", grant_o, 0);
    end
    // gap cycles, then the IDLE cycle; done pulses here must be ignored
    for (int g = 0; g < G; g++) begin
      tx_done_i = 1'($urandom % 2);
      tick();
      chk("gap_quiet", {23'd0, tx_start_o, ack_o, grant_o, err_o}, 32'd0);
    end
    tx_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_i     = N'($urandom);
      data_i    = {$urandom};
      tx_busy_i = 1'($urandom);
      tx_done_i = 1'($urandom);
      tick();
      chk("rst_outs", {14'd0, ack_o, tx_start_o, tx_data_o, grant_o, err_o}, 32'd0);
    end
    req_i = '0; tx_busy_i = 1'b0; tx_done_i = 1'b0;
    rst_ni = 1'b1;
    mptr = 0;
  endtask

  initial begin
    int w;
    logic [N-1:0] r, nw, wd;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_quiet", {23'd0, tx_start_o, ack_o, grant_o, err_o}, 32'd0);
    end

    // single source, 5 clocks/bit x 11 bits
    data_i[2*W +: W] = 8'h16;
    frame(4'b0100, 0, 55, 0, w);
    chk("single_win", w, 2);

    // fairness with all four held high
    do_reset();
    data_i = {8'h26, 8'h1E, 8'h16, 8'h45};
    for (int k = 0; k < 8; k++) begin
      frame(4'b1111, 0, 1 + int'($urandom_range(0, 20)), 1, w);
      chk("rr_order", w, k % 4);
    end
    req_i = '0;

    // busy hold-off
    frame(4'b0001, 4, 10, 0, w);

    // hung transmitter, then next requester served after the gap
    frame(4'b0010, 0, T + 1, 0, w);
    frame(4'b0100, 0, 12, 0, w);
    chk("after_wd_win", w, 2);
    // done exactly at expiry: no err
    frame(4'b1000, 0, T, 0, w);

    // withdrawal: req[1] pending under busy, dropped before it can win
    req_i = 4'b0010; tx_busy_i = 1'b1;
    tick();
    chk("wd_pending", {27'd0, tx_start_o, ack_o}, 32'd0);
    frame(4'b0001, 2, 8, 0, w);
    chk("withdraw_win", w, 0);

    // reset during WAIT after source 1 won
    req_i = 4'b0010;
    tick();
    chk("pre_rst_start", tx_start_o, 1);
    req_i = '0; tx_busy_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("async_rst", {14'd0, ack_o, tx_start_o, tx_data_o, grant_o, err_o}, 32'd0);
    tx_busy_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1; mptr = 0;
    frame(4'b1001, 0, 6, 0, w);
    chk("ptr_reset", w, 0);
    req_i[3] = 1'b0;
    frame(4'b1000, 0, 6, 0, w);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < N; j++) if (!req_i[j]) data_i[j*W +: W] = W'($urandom);
      nw = N'($urandom);
      wd = N'($urandom) & N'($urandom);
      r  = (req_i | nw) & ~wd;
      if (r == '0) r = N'(1) << $urandom_range(0, N - 1);
      frame(r, int'($urandom_range(0, 3)),
            ($urandom % 8 == 0) ? T + 1 : 1 + int'($urandom_range(0, 40)),
            1'($urandom), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
